// File: rtl/parser_pkg.sv
// Shared types and helpers for the parser frame sequencer.
package parser_pkg;

    localparam int unsigned HDR_BYTES_C = 18;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        CLASSIFY,
        FORWARD,
        DROP
    } seq_state_t;

    // Sized for the widest supported bus (512 bits -> 64 keep bits); callers zero-extend.
    function automatic logic [6:0] keep_popcount(input logic [63:0] keep);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/parser_frame_sequencer.sv
// Per-frame control of header capture, classification handshake and payload forward/discard.
module parser_frame_sequencer
    import parser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned HDR_BYTES  = HDR_BYTES_C,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    output logic                    s_axis_tready,
    output logic                    frame_start,
    output logic                    beat_accept,
    input  logic                    header_valid,
    output logic                    cls_req,
    input  logic                    cls_ack,
    input  logic                    cls_drop,
    input  logic                    fwd_ready,
    output logic                    fwd_en,
    output logic [CNT_WIDTH-1:0]    frame_cnt,
    output logic [CNT_WIDTH-1:0]    drop_cnt,
    output logic [CNT_WIDTH-1:0]    runt_cnt
);

    localparam int unsigned KEEP_W = DATA_WIDTH / 8;

    seq_state_t           state_q, state_d;
    logic [5:0]           byte_cnt_q, byte_cnt_d;
    logic                 tail_seen_q, tail_seen_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0] runt_cnt_q, runt_cnt_d;

    logic [63:0] keep_ext;
    logic [6:0]  nbytes;
    logic [7:0]  byte_sum;
    logic        hdr_done;
    logic        hs;

    always_comb begin
        keep_ext = '0;
        keep_ext[KEEP_W-1:0] = s_axis_tkeep;
        nbytes   = keep_popcount(keep_ext);
        byte_sum = {2'b00, byte_cnt_q} + {1'b0, nbytes};
        hdr_done = (byte_sum >= 8'(HDR_BYTES));
    end

    always_comb begin
        unique case (state_q)
            CAPTURE: s_axis_tready = 1'b1;
            FORWARD: s_axis_tready = fwd_ready;
            DROP:    s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
    end

    assign hs = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        tail_seen_d = tail_seen_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        runt_cnt_d  = runt_cnt_q;
        frame_start = 1'b0;
        beat_accept = 1'b0;
        cls_req     = 1'b0;
        fwd_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Gated by rst so every output reads 0 while reset is held with tvalid high.
                frame_start = s_axis_tvalid & ~rst;
                if (s_axis_tvalid) begin
                    byte_cnt_d  = '0;
                    tail_seen_d = 1'b0;
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: begin
                beat_accept = hs;
                if (hs) begin
                    byte_cnt_d = hdr_done ? 6'(HDR_BYTES) : byte_sum[5:0];
                    if (hdr_done) begin
                        tail_seen_d = s_axis_tlast;
                        state_d     = CLASSIFY;
                    end else if (s_axis_tlast) begin
                        if (runt_cnt_q != '1) runt_cnt_d = runt_cnt_q + CNT_WIDTH'(1);
                        state_d = IDLE;
                    end
                end
            end
            CLASSIFY: begin
                cls_req = header_valid;
                if (header_valid && cls_ack) begin
                    if (cls_drop) begin
                        if (tail_seen_q) begin
                            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                            state_d = IDLE;
                        end else begin
                            state_d = DROP;
                        end
                    end else if (tail_seen_q) begin
                        if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                        state_d = IDLE;
                    end else begin
                        state_d = FORWARD;
                    end
                end
            end
            FORWARD: begin
                fwd_en = 1'b1;
                if (hs && s_axis_tlast) begin
                    if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (hs && s_axis_tlast) begin
                    if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            tail_seen_q <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            runt_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            tail_seen_q <= tail_seen_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            runt_cnt_q  <= runt_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign runt_cnt  = runt_cnt_q;

endmodule
